// File: rtl/veryrisc_sequencer.sv
// rtl/veryrisc_sequencer.sv - VeryRISC instruction phase sequencer and instruction register
module veryrisc_sequencer #(
   parameter int IR_WIDTH     = 8,
   parameter int OPCODE_WIDTH = 3,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [IR_WIDTH-1:0]              data_in,
   input  logic                             ld_ir,
   input  logic                             halt,
   input  logic                             go,
   input  logic                             step_mode,
   output logic [2:0]                       phase,
   output logic [OPCODE_WIDTH-1:0]          opcode,
   output logic [IR_WIDTH-OPCODE_WIDTH-1:0] ir_addr,
   output logic                             halted,
   output logic                             step_wait,
   output logic [CNT_WIDTH-1:0]             instr_count
);

   // Encoding 2'b11 is unused; the next-state logic steers it back to RUN at phase 0.
   typedef enum logic [1:0] {
      ST_RUN       = 2'b00,
      ST_HALTED    = 2'b01,
      ST_STEP_WAIT = 2'b10
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [2:0]             phase_nxt;
   logic [CNT_WIDTH-1:0]   cnt_nxt;
   logic [IR_WIDTH-1:0]    ir;

   // State, phase, retired count and IR registers; reset wins over every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_RUN;
         phase       <= 3'd0;
         ir          <= '0;
         instr_count <= '0;
      end else begin
         state       <= state_nxt;
         phase       <= phase_nxt;
         instr_count <= cnt_nxt;
         if (ld_ir) begin
            ir <= data_in;
         end
      end
   end

   // Next-state decode: phase stepping, HLT freeze at phase 5, step stop at the instruction boundary.
   always_comb begin
      state_nxt = state;
      phase_nxt = phase;
      cnt_nxt   = instr_count;
      case (state)
         ST_RUN: begin
            if (phase == 3'd4 && halt) begin
               // Parking at 5 means the HLT decode drives no controls while frozen.
               phase_nxt = 3'd5;
               state_nxt = ST_HALTED;
            end else begin
               phase_nxt = phase + 3'd1;
               if (phase == 3'd7) begin
                  cnt_nxt = instr_count + CNT_WIDTH'(1);
                  if (step_mode) begin
                     state_nxt = ST_STEP_WAIT;
                  end
               end
            end
         end
         ST_HALTED: begin
            if (go) begin
               // Resume finishes the halted instruction so it is counted at 7->0.
               phase_nxt = 3'd6;
               state_nxt = ST_RUN;
            end
         end
         ST_STEP_WAIT: begin
            phase_nxt = 3'd0;
            if (go) begin
               phase_nxt = 3'd1;
               state_nxt = ST_RUN;
            end
         end
         default: begin
            phase_nxt = 3'd0;
            state_nxt = ST_RUN;
         end
      endcase
   end

   assign opcode    = ir[IR_WIDTH-1 -: OPCODE_WIDTH];
   assign ir_addr   = ir[IR_WIDTH-OPCODE_WIDTH-1:0];
   assign halted    = (state == ST_HALTED);
   assign step_wait = (state == ST_STEP_WAIT);

endmodule

// File: doc/veryrisc_sequencer.md
Name: veryrisc_sequencer

Overview:
- Upstream timing-and-decode-source stage for the VeryRISC controller.
- Generates the 3-bit instruction phase (0..7) and holds the instruction register. Provides opcode/address fields to the controller and datapath.
- Freezes the machine on HLT and supports resume plus single-instruction stepping.
- Consumes the controller's ld_ir and halt strobes and the memory read bus.

Parameters:
- IR_WIDTH, 8, instruction register width
- OPCODE_WIDTH, 3, opcode field width (MSBs of IR)
- CNT_WIDTH, 16, retired-instruction counter width

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- data_in  input  IR_WIDTH  memory read data bus
- ld_ir  input  1  load IR from data_in (controller output)
- halt  input  1  halt request (controller output, valid in phase 4)
- go  input  1  resume/step pulse, level sampled each clock
- step_mode  input  1  1 = stop at every instruction boundary
- phase  output  3  current instruction phase
- opcode  output  OPCODE_WIDTH  IR[IR_WIDTH-1 -: OPCODE_WIDTH]
- ir_addr  output  IR_WIDTH-OPCODE_WIDTH  IR low field (operand address)
- halted  output  1  1 while in HALTED state
- step_wait  output  1  1 while in STEP_WAIT state
- instr_count  output  CNT_WIDTH  retired instructions, wraps

Behaviour:
- Reset (rst=1 at edge) has priority over all other inputs and may occur mid-instruction or in any state. It forces:
  - state=RUN, phase=0, IR=0 (opcode=HLT), instr_count=0
  - halted=0, step_wait=0
- States:
  - RUN: phase advances 0→1→...→7→0 each clock.
  - HALTED: phase holds.
  - STEP_WAIT: phase holds at 0.
- RUN transitions:
  - halt=1 sampled while phase==4: phase←5, state←HALTED. This takes priority over step_mode.
  - halt sampled in any other phase is ignored.
  - Phase 7→0 transition: instr_count←instr_count+1, modulo 2^CNT_WIDTH, wrapping all-ones→0.
  - Phase 7→0 with step_mode=1: state←STEP_WAIT.
  - go is ignored in RUN.
- HALTED:
  - Phase held at 5, where HLT decode drives no controls.
  - go=1: state←RUN, phase←6. The instruction then completes normally, 6→7→0, and is counted at 7→0.
  - halt input is ignored while in HALTED.
- STEP_WAIT:
  - Phase held at 0.
  - go=1: state←RUN, phase←1.
  - step_mode deasserted while waiting does not release the state; only go releases it.
- IR:
  - ld_ir=1 at an edge: IR←data_in. Otherwise IR holds.
  - ld_ir is honoured in any state. The last load wins when asserted on consecutive phases 2 and 3.
- Outputs:
  - All outputs are registered or direct decodes of registers, with no combinational path from inputs.
  - opcode and ir_addr update the cycle after the loading edge.
  - halted and step_wait are decodes of the state register.
- No illegal states: any unencoded state value recovers to RUN with phase=0.

Test Plan:
- Reset, then 16 clocks with halt=0, step_mode=0 → phase sequence 0..7,0..7. instr_count=2 after the 2nd 7→0 edge.
- data_in=8'hA5 with ld_ir=1 in phases 2 and 3 → opcode=3'b101, ir_addr=5'h05 from phase 3 onward. Hold through phase 7 with ld_ir=0.
- halt=1 at phase 4 → phase=5 and halted=1, held for 10 clocks. go=1 for one clock → phases 6,7,0 and instr_count increments by 1.
- halt=1 in phase 2 → ignored, sequence continues to 3.
- step_mode=1 → after phase 7, phase=0 and step_wait=1, held. go pulse → phase 1,2,...,7, then 0 with step_wait=1 again.
- Preload instr_count to 16'hFFFF via 65535 instructions, or force in bench, then complete one instruction → instr_count=0.
- rst asserted in HALTED at phase 5 → next cycle: phase=0, halted=0, opcode=0, instr_count=0.
